// File: rtl/tsp_ram_arbiter_if.sv
// rtl/tsp_ram_arbiter_if.sv - request/response and RAM port bundle for tsp_ram_arbiter
//   a_*   : AXI register path requester (write/read, byte strobes, grant, read return)
//   b_*   : TS filter scanner requester (read only)
//   clr_* : clear engine control and status
//   mem_* : single port of the filter logic RAM (read data one cycle after mem_rden)
//   slave modport = arbiter view, master modport = requesters + RAM view
interface tsp_ram_arbiter_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int OPT_MEM_ADDR_BITS  = 10
);
  localparam int AW = OPT_MEM_ADDR_BITS + 1;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  logic                          a_wr_req;
  logic                          a_rd_req;
  logic [AW-1:0]                 a_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] a_wdata;
  logic [SW-1:0]                 a_wstrb;
  logic                          a_grant;
  logic                          a_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] a_rdata;

  logic                          b_rd_req;
  logic [AW-1:0]                 b_addr;
  logic                          b_grant;
  logic                          b_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] b_rdata;

  logic                          clr_start;
  logic                          clr_busy;
  logic                          clr_done;

  logic [AW-1:0]                 mem_address;
  logic                          mem_wren;
  logic                          mem_rden;
  logic [C_S_AXI_DATA_WIDTH-1:0] mem_wdata;
  logic [SW-1:0]                 mem_wstrb;
  logic [C_S_AXI_DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  a_wr_req, a_rd_req, a_addr, a_wdata, a_wstrb,
    input  b_rd_req, b_addr,
    input  clr_start,
    input  mem_rdata,
    output a_grant, a_rvalid, a_rdata,
    output b_grant, b_rvalid, b_rdata,
    output clr_busy, clr_done,
    output mem_address, mem_wren, mem_rden, mem_wdata, mem_wstrb
  );

  modport master (
    output a_wr_req, a_rd_req, a_addr, a_wdata, a_wstrb,
    output b_rd_req, b_addr,
    output clr_start,
    output mem_rdata,
    input  a_grant, a_rvalid, a_rdata,
    input  b_grant, b_rvalid, b_rdata,
    input  clr_busy, clr_done,
    input  mem_address, mem_wren, mem_rden, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/tsp_ram_arbiter.sv
// rtl/tsp_ram_arbiter.sv - round-robin arbiter and clear engine for the TSP filter logic RAM
//   S_AXI_ACLK : sole clock
//   rst        : asynchronous active-high reset
//   bus        : tsp_ram_arbiter_if.slave (requesters A/B, clear control, RAM port)
module tsp_ram_arbiter #(
  parameter int                          C_S_AXI_DATA_WIDTH = 32,
  parameter int                          OPT_MEM_ADDR_BITS  = 10,
  parameter int                          TSP_FILTER_NUM     = 32,
  parameter int                          WORDS_PER_FILTER   = 4,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] CLEAR_VALUE      = 32'h00001FFF,
  parameter int                          AUTO_CLEAR         = 1
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  rst,
  tsp_ram_arbiter_if.slave      bus
);
  localparam int AW = OPT_MEM_ADDR_BITS + 1;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam int N  = TSP_FILTER_NUM * WORDS_PER_FILTER;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t                        r_state;
  state_t                        w_next_state;

  logic                          r_auto_pend;
  logic                          r_rr_b;
  logic [AW-1:0]                 r_clr_cnt;
  logic                          r_clr_last;

  logic [AW-1:0]                 r_mem_address;
  logic                          r_mem_wren;
  logic                          r_mem_rden;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_mem_wdata;
  logic [SW-1:0]                 r_mem_wstrb;
  logic                          r_mem_tag;

  logic                          r_rd_v2;
  logic                          r_rd_tag2;
  logic                          r_a_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_a_rdata;
  logic                          r_b_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_b_rdata;

  logic                          w_a_req;
  logic                          w_a_grant;
  logic                          w_b_grant;
  logic                          w_clr_busy;
  logic                          w_clr_done;
  logic                          w_clr_issue;

  assign w_a_req = bus.a_wr_req | bus.a_rd_req;
  // The final CLEAR cycle issues nothing; it lets the last write reach the RAM port while busy.
  assign w_clr_issue = (r_state == S_CLEAR) && !r_clr_last;

  always_ff @(posedge S_AXI_ACLK or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.clr_start || r_auto_pend) w_next_state = S_CLEAR;
      S_CLEAR: if (r_clr_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_a_grant  = 1'b0;
    w_b_grant  = 1'b0;
    w_clr_busy = 1'b0;
    w_clr_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        // r_auto_pend blocks the cycle right after reset release, which is already committed to clearing.
        if (!rst && !r_auto_pend) begin
          if (w_a_req && (!bus.b_rd_req || !r_rr_b)) w_a_grant = 1'b1;
          else if (bus.b_rd_req)                     w_b_grant = 1'b1;
        end
      end
      S_CLEAR: w_clr_busy = 1'b1;
      S_DONE:  w_clr_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge rst) begin
    if (rst) begin
      r_auto_pend <= (AUTO_CLEAR != 0);
      r_clr_cnt   <= '0;
      r_clr_last  <= 1'b0;
    end else begin
      r_auto_pend <= 1'b0;
      if (w_clr_issue) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
        if (r_clr_cnt == LAST_ADDR) r_clr_last <= 1'b1;
      end else if (r_state != S_CLEAR) begin
        r_clr_cnt  <= '0;
        r_clr_last <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge rst) begin
    if (rst) begin
      r_mem_address <= '0;
      r_mem_wren    <= 1'b0;
      r_mem_rden    <= 1'b0;
      r_mem_wdata   <= '0;
      r_mem_wstrb   <= '0;
      r_mem_tag     <= 1'b0;
      r_rr_b        <= 1'b0;
    end else begin
      r_mem_wren <= 1'b0;
      r_mem_rden <= 1'b0;
      if (w_clr_issue) begin
        r_mem_address <= r_clr_cnt;
        r_mem_wren    <= 1'b1;
        r_mem_wdata   <= CLEAR_VALUE;
        r_mem_wstrb   <= '1;
      end else if (w_a_grant) begin
        r_mem_address <= bus.a_addr;
        r_rr_b        <= 1'b1;
        if (bus.a_wr_req) begin
          r_mem_wren  <= 1'b1;
          r_mem_wdata <= bus.a_wdata;
          r_mem_wstrb <= bus.a_wstrb;
        end else begin
          r_mem_rden  <= 1'b1;
          r_mem_tag   <= 1'b0;
        end
      end else if (w_b_grant) begin
        r_mem_address <= bus.b_addr;
        r_mem_rden    <= 1'b1;
        r_mem_tag     <= 1'b1;
        r_rr_b        <= 1'b0;
      end
    end
  end

  // Tag follows the read through the RAM's one-cycle latency, then steers the data to its owner.
  always_ff @(posedge S_AXI_ACLK or posedge rst) begin
    if (rst) begin
      r_rd_v2    <= 1'b0;
      r_rd_tag2  <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rvalid <= 1'b0;
      r_b_rdata  <= '0;
    end else begin
      r_rd_v2    <= r_mem_rden;
      r_rd_tag2  <= r_mem_tag;
      r_a_rvalid <= r_rd_v2 && !r_rd_tag2;
      r_b_rvalid <= r_rd_v2 &&  r_rd_tag2;
      if (r_rd_v2 && !r_rd_tag2) r_a_rdata <= bus.mem_rdata;
      if (r_rd_v2 &&  r_rd_tag2) r_b_rdata <= bus.mem_rdata;
    end
  end

  assign bus.a_grant     = w_a_grant;
  assign bus.b_grant     = w_b_grant;
  assign bus.clr_busy    = w_clr_busy;
  assign bus.clr_done    = w_clr_done;
  assign bus.a_rvalid    = r_a_rvalid;
  assign bus.a_rdata     = r_a_rdata;
  assign bus.b_rvalid    = r_b_rvalid;
  assign bus.b_rdata     = r_b_rdata;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_wren    = r_mem_wren;
  assign bus.mem_rden    = r_mem_rden;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.mem_wstrb   = r_mem_wstrb;
endmodule

// File: tb/tb_tsp_ram_arbiter.sv
// tb/tb_tsp_ram_arbiter.sv - self-checking bench for tsp_ram_arbiter
module tb_tsp_ram_arbiter;
  localparam int DW = 32;
  localparam int AM = 10;
  localparam int N  = 128;
  localparam logic [31:0] CLRV = 32'h00001FFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  tsp_ram_arbiter_if #(.C_S_AXI_DATA_WIDTH(DW), .OPT_MEM_ADDR_BITS(AM)) bus ();

  tsp_ram_arbiter #(
    .C_S_AXI_DATA_WIDTH(DW), .OPT_MEM_ADDR_BITS(AM), .TSP_FILTER_NUM(32),
    .WORDS_PER_FILTER(4), .CLEAR_VALUE(CLRV), .AUTO_CLEAR(1)
  ) dut (
    .S_AXI_ACLK(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM behavioural model (environment, not the reference)
  logic [31:0] ram [0:2047];
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_address] <= merge(ram[bus.mem_address], bus.mem_wdata, bus.mem_wstrb);
    if (bus.mem_rden) bus.mem_rdata <= ram[bus.mem_address];
  end

  // Reference model: expected contents, clear window, round-robin and read returns
  typedef struct { bit is_b; logic [31:0] data; int due; } rd_t;
  rd_t         q[$];
  logic [31:0] gold [0:2047];
  int          clr_left = 0;
  int          clr_cnt  = 0;
  int          n_done   = 0;
  bit          auto_pend = 1'b1;
  bit          prio_a    = 1'b1;
  bit          ev_wr = 1'b0, ev_rd = 1'b0;
  logic [10:0] ev_addr;
  logic [31:0] ev_wdata;
  logic [3:0]  ev_wstrb;
  logic [31:0] last_a = '0, last_b = '0;

  always @(negedge clk) begin
    int  cl;
    bit  avail, ega, egb, clrw, eav, ebv, ew;
    logic [31:0] ad, bd;
    if (rst) begin
      chk("rst_flags", {bus.a_grant, bus.b_grant, bus.a_rvalid, bus.b_rvalid,
                        bus.clr_busy, bus.clr_done, bus.mem_wren, bus.mem_rden}, 0);
      chk("rst_data", bus.a_rdata | bus.b_rdata | bus.mem_wdata | {21'b0, bus.mem_address} | {28'b0, bus.mem_wstrb}, 0);
      clr_left = 0; clr_cnt = 0; auto_pend = 1'b1; prio_a = 1'b1;
      ev_wr = 1'b0; ev_rd = 1'b0; last_a = '0; last_b = '0;
      q.delete();
    end else begin
      cl    = clr_left;
      avail = (cl == 0) && !auto_pend;
      ega   = avail && (bus.a_wr_req || bus.a_rd_req) && (!bus.b_rd_req || prio_a);
      egb   = avail && bus.b_rd_req && !ega;
      chk("a_grant", bus.a_grant, ega);
      chk("b_grant", bus.b_grant, egb);
      chk("clr_busy", bus.clr_busy, cl > 1);
      chk("clr_done", bus.clr_done, cl == 1);

      clrw = (cl >= 2) && (cl <= N + 1);
      ew   = ev_wr || clrw;
      chk("mem_wren", bus.mem_wren, ew);
      chk("mem_rden", bus.mem_rden, ev_rd);
      if (ew) begin
        chk("wr_addr",  bus.mem_address, ev_wr ? ev_addr  : 11'(N + 1 - cl));
        chk("wr_data",  bus.mem_wdata,   ev_wr ? ev_wdata : CLRV);
        chk("wr_strb",  bus.mem_wstrb,   ev_wr ? ev_wstrb : 4'hF);
      end
      if (ev_rd) chk("rd_addr", bus.mem_address, ev_addr);
      if (clrw) clr_cnt++;

      eav = 1'b0; ebv = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        if (q[0].is_b) begin ebv = 1'b1; last_b = q[0].data; end
        else           begin eav = 1'b1; last_a = q[0].data; end
        void'(q.pop_front());
      end
      chk("a_rvalid", bus.a_rvalid, eav);
      chk("b_rvalid", bus.b_rvalid, ebv);
      ad = last_a; bd = last_b;
      chk("a_rdata", bus.a_rdata, ad);
      chk("b_rdata", bus.b_rdata, bd);

      ev_wr = 1'b0; ev_rd = 1'b0;
      if (ega) begin
        ev_addr = bus.a_addr;
        prio_a  = 1'b0;
        if (bus.a_wr_req) begin
          ev_wr = 1'b1; ev_wdata = bus.a_wdata; ev_wstrb = bus.a_wstrb;
          gold[bus.a_addr] = merge(gold[bus.a_addr], bus.a_wdata, bus.a_wstrb);
        end else begin
          ev_rd = 1'b1;
          q.push_back('{is_b: 1'b0, data: gold[bus.a_addr], due: cyc + 3});
        end
      end else if (egb) begin
        ev_addr = bus.b_addr; ev_rd = 1'b1; prio_a = 1'b1;
        q.push_back('{is_b: 1'b1, data: gold[bus.b_addr], due: cyc + 3});
      end

      if (cl == 1) begin
        chk("clear_writes", clr_cnt, N);
        for (int i = 0; i < N; i++) gold[i] = CLRV;
        clr_cnt = 0;
        n_done++;
      end
      if (cl > 0) clr_left = cl - 1;
      if (cl == 0 && (auto_pend || bus.clr_start)) clr_left = N + 2;
      auto_pend = 1'b0;
    end
  end

  task automatic a_access(input bit wr, input logic [10:0] addr, input logic [31:0] d,
                          input logic [3:0] s, output int gcyc);
    bus.a_wr_req = wr; bus.a_rd_req = !wr; bus.a_addr = addr; bus.a_wdata = d; bus.a_wstrb = s;
    gcyc = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.a_grant) begin gcyc = cyc; break; end
    end
    chk("a_grant_wait", gcyc >= 0, 1);
    @(posedge clk); #1;
    bus.a_wr_req = 1'b0; bus.a_rd_req = 1'b0;
  endtask

  task automatic b_access(input logic [10:0] addr, output int gcyc);
    bus.b_rd_req = 1'b1; bus.b_addr = addr;
    gcyc = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.b_grant) begin gcyc = cyc; break; end
    end
    chk("b_grant_wait", gcyc >= 0, 1);
    @(posedge clk); #1;
    bus.b_rd_req = 1'b0;
  endtask

  task automatic run_traffic(input int cycles, input int pa, input int pb, input int pw,
                             output int na, output int nb);
    bit ga = 1'b0, gb = 1'b0, act_a = 1'b0, act_b = 1'b0;
    na = 0; nb = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ga || !act_a) begin
        act_a = ($urandom_range(99) < pa);
        bus.a_wr_req = act_a && ($urandom_range(99) < pw);
        bus.a_rd_req = act_a && !bus.a_wr_req;
        bus.a_addr   = 11'($urandom_range(127));
        bus.a_wdata  = $urandom;
        bus.a_wstrb  = 4'($urandom_range(15));
      end
      if (gb || !act_b) begin
        act_b = ($urandom_range(99) < pb);
        bus.b_rd_req = act_b;
        bus.b_addr   = 11'($urandom_range(127));
      end
      @(negedge clk);
      ga = bus.a_grant; gb = bus.b_grant;
      na += int'(ga); nb += int'(gb);
    end
    @(posedge clk); #1;
    bus.a_wr_req = 1'b0; bus.a_rd_req = 1'b0; bus.b_rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, g2, c0, na, nb, nw, first;
    bit found, done;
    for (int i = 0; i < 2048; i++) begin ram[i] = '0; gold[i] = '0; end
    bus.a_wr_req = 0; bus.a_rd_req = 0; bus.a_addr = '0; bus.a_wdata = '0; bus.a_wstrb = '0;
    bus.b_rd_req = 0; bus.b_addr = '0; bus.clr_start = 0; bus.mem_rdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    c0 = cyc;

    // Auto-clear: a read held from release is granted only after clr_done
    a_access(1'b0, 11'd3, '0, '0, g);
    chk("auto_grant_cycle", g - c0, N + 3);

    // A write then read of address 5
    a_access(1'b1, 11'd5, 32'hDEADBEEF, 4'hF, g);
    a_access(1'b0, 11'd5, '0, '0, g);
    @(negedge clk);
    chk("rd5_rden", bus.mem_rden, 1);
    chk("rd5_addr", bus.mem_address, 5);
    @(negedge clk);
    @(negedge clk);
    chk("rd5_rvalid", bus.a_rvalid, 1);
    chk("rd5_rdata", bus.a_rdata, 32'hDEADBEEF);
    chk("rd5_b_rvalid", bus.b_rvalid, 0);

    // Partial-strobe write over a cleared word, read back by B
    a_access(1'b1, 11'd7, 32'h12345678, 4'b0011, g);
    @(negedge clk);
    chk("wr7_strb", bus.mem_wstrb, 4'b0011);
    b_access(11'd7, g);
    repeat (3) @(negedge clk);
    chk("rd7_b_rvalid", bus.b_rvalid, 1);
    chk("rd7_b_rdata", bus.b_rdata, 32'h00005678);

    // Both requesters continuously pending: strict alternation
    run_traffic(20, 100, 100, 0, na, nb);
    chk("alt_a_count", na, 10);
    chk("alt_b_count", nb, 10);
    repeat (4) @(posedge clk);
    #1;

    // clr_start in the same cycle as a B grant; a second clr_start mid-clear is ignored
    bus.b_rd_req = 1'b1; bus.b_addr = 11'd9; bus.clr_start = 1'b1;
    @(negedge clk);
    chk("clrb_grant", bus.b_grant, 1);
    g = cyc; g2 = -1;
    for (int k = 1; k < 600; k++) begin
      @(posedge clk); #1;
      bus.clr_start = (k == 20);
      if (k == 1) bus.b_addr = 11'd10;
      @(negedge clk);
      if (k == 3) begin
        chk("clrb_rvalid", bus.b_rvalid, 1);
        chk("clrb_rdata", bus.b_rdata, CLRV);
      end
      if (bus.b_grant) begin g2 = cyc; break; end
    end
    chk("clrb_resume", g2 - g, N + 3);
    @(posedge clk); #1;
    bus.b_rd_req = 1'b0; bus.clr_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of a clear, then restart from address 0
    bus.clr_start = 1'b1;
    @(posedge clk); #1;
    bus.clr_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.mem_wren && bus.mem_address == 11'd40) begin found = 1'b1; break; end
    end
    chk("mid_clear_reached", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_wren", bus.mem_wren, 0);
    chk("abort_addr", bus.mem_address, 0);
    chk("abort_busy", bus.clr_busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    nw = 0; first = -1; done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.mem_wren) begin
        if (nw == 0) first = int'(bus.mem_address);
        nw++;
      end
      if (bus.clr_done) begin done = 1'b1; break; end
    end
    chk("restart_done", done, 1);
    chk("restart_writes", nw, N);
    chk("restart_first", first, 0);

    // Randomized mixed traffic against the reference model
    run_traffic(300, 60, 60, 40, na, nb);
    repeat (8) @(negedge clk);
    chk("reads_drained", q.size(), 0);
    chk("done_pulses", n_done, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
